// File: rtl/mipse_cpu.sv
// mipse_cpu: five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with
// full forwarding, a one-cycle load-use stall, J resolved in ID and BEQ/BNE in EX.

module mipse_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    // Write-through so the instruction in ID sees the value retiring in WB this cycle.
    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
        if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
        if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
    end
endmodule

module mipse_cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] readdata,
    output logic [31:0] pc,
    output logic [31:0] aluout,
    output logic [31:0] writedata,
    output logic        memwrite
);
    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              branch;
        logic              bne;
        logic              alusrc;
        alu_op_e           alu_op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dst;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
    } idex_t;

    typedef struct packed {
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [4:0]        dst;
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] wdata;
    } exmem_t;

    typedef struct packed {
        logic              regwrite;
        logic              memread;
        logic [4:0]        dst;
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] rdata;
    } memwb_t;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [DATA_W-1:0] ifid_pc4_q, ifid_pc4_d;
    idex_t             idex_q, idex_d, dec;
    exmem_t            exmem_q, exmem_d;
    memwb_t            memwb_q, memwb_d;

    logic [5:0]        opcode, funct;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              uses_rs, uses_rt, is_jump;
    logic              stall, branch_taken;
    logic [DATA_W-1:0] rf_rd1, rf_rd2, wb_value;
    logic [DATA_W-1:0] fwd_a, fwd_b, src_b, alu_result;
    logic [DATA_W-1:0] pc_plus4, jump_target, branch_target;
    logic              unused_shamt;

    assign opcode       = ifid_instr_q[31:26];
    assign id_rs        = ifid_instr_q[25:21];
    assign id_rt        = ifid_instr_q[20:16];
    assign id_rd        = ifid_instr_q[15:11];
    assign funct        = ifid_instr_q[5:0];
    assign unused_shamt = ^ifid_instr_q[10:6];

    assign wb_value = memwb_q.memread ? memwb_q.rdata : memwb_q.aluout;

    mipse_rf rfile_1 (
        .clk (clk),
        .rst (rst),
        .ra1 (id_rs),
        .ra2 (id_rt),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (memwb_q.regwrite),
        .wa  (memwb_q.dst),
        .wd  (wb_value)
    );

    always_comb begin
        dec      = '0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        is_jump  = 1'b0;
        dec.rs   = id_rs;
        dec.rt   = id_rt;
        dec.rd1  = rf_rd1;
        dec.rd2  = rf_rd2;
        dec.imm  = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
        dec.pc4  = ifid_pc4_q;
        case (opcode)
            OP_RTYPE: begin
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
                dec.dst      = id_rd;
                dec.regwrite = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: dec.regwrite = 1'b0;
                endcase
            end
            OP_ADDI: begin
                uses_rs      = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.dst      = id_rt;
            end
            OP_LW: begin
                uses_rs      = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.dst      = id_rt;
            end
            OP_SW: begin
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
                dec.branch = 1'b1;
                dec.bne    = (opcode == OP_BNE);
            end
            OP_J:    is_jump = 1'b1;
            default: ;
        endcase
    end

    assign stall = idex_q.memread && idex_q.dst != 5'd0 &&
                   ((uses_rs && id_rs == idex_q.dst) || (uses_rt && id_rt == idex_q.dst));

    // EX/MEM wins over MEM/WB because it holds the younger result.
    always_comb begin
        fwd_a = idex_q.rd1;
        fwd_b = idex_q.rd2;
        if (exmem_q.regwrite && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rs)
            fwd_a = exmem_q.aluout;
        else if (memwb_q.regwrite && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rs)
            fwd_a = wb_value;
        if (exmem_q.regwrite && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rt)
            fwd_b = exmem_q.aluout;
        else if (memwb_q.regwrite && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rt)
            fwd_b = wb_value;
        src_b = idex_q.alusrc ? idex_q.imm : fwd_b;
        case (idex_q.alu_op)
            ALU_SUB: alu_result = fwd_a - src_b;
            ALU_AND: alu_result = fwd_a & src_b;
            ALU_OR:  alu_result = fwd_a | src_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
            default: alu_result = fwd_a + src_b;
        endcase
    end

    assign branch_taken  = idex_q.branch && ((fwd_a == fwd_b) != idex_q.bne);
    assign branch_target = idex_q.pc4 + {idex_q.imm[DATA_W-3:0], 2'b00};
    assign pc_plus4      = pc_q + DATA_W'(4);
    assign jump_target   = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};

    // A taken branch outranks both the stall and a J sitting behind it in ID.
    always_comb begin
        pc_d         = pc_plus4;
        ifid_instr_d = instr;
        ifid_pc4_d   = pc_plus4;
        idex_d       = dec;
        if (branch_taken) begin
            pc_d         = branch_target;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            idex_d       = '0;
        end else if (stall) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
            idex_d       = '0;
        end else if (is_jump) begin
            pc_d         = jump_target;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
        end
    end

    always_comb begin
        exmem_d          = '0;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.dst      = idex_q.dst;
        exmem_d.aluout   = alu_result;
        exmem_d.wdata    = fwd_b;
        memwb_d          = '0;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memread  = exmem_q.memread;
        memwb_d.dst      = exmem_q.dst;
        memwb_d.aluout   = exmem_q.aluout;
        memwb_d.rdata    = readdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
        end
    end

    assign pc        = pc_q;
    assign aluout    = exmem_q.aluout;
    assign writedata = exmem_q.wdata;
    assign memwrite  = exmem_q.memwrite;
endmodule

// File: tb/tb_mipse_cpu.sv
// tb_mipse_cpu: runs directed and random programs on mipse_cpu and compares
// registers, memory, stall count and halt timing against an ISA-level model.

module tb_mipse_cpu;
    localparam int CYCLE_BUDGET = 2000;

    logic        clk;
    logic        rst;
    logic [31:0] instr, readdata, pc, aluout, writedata;
    logic        memwrite;

    logic [31:0] imem [0:65535];
    logic [31:0] dmem [0:65535];
    logic [31:0] mmem [0:65535];
    logic [31:0] mreg [0:31];

    int          total = 0;
    int          bad = 0;
    int          mExec, mStalls, mJumps, mTaken;
    logic [31:0] mHaltData;
    int          stallCount, haltCycle;
    logic [31:0] haltData;
    logic [31:0] pcTrace [$];

    mipse_cpu dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .readdata  (readdata),
        .pc        (pc),
        .aluout    (aluout),
        .writedata (writedata),
        .memwrite  (memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr    = imem[pc[17:2]];
    assign readdata = dmem[aluout[17:2]];

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encJ(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    // Which registers an instruction reads, straight from the ISA definition.
    function automatic bit readsReg(input logic [31:0] w, input logic [4:0] r);
        logic [5:0] op;
        bit rsRead, rtRead;
        op = w[31:26];
        rsRead = (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h05);
        rtRead = (op == 6'h00 || op == 6'h2b || op == 6'h04 || op == 6'h05);
        return (rsRead && w[25:21] == r) || (rtRead && w[20:16] == r);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    endtask

    task automatic loadData();
        for (int i = 0; i < 64; i++) begin
            dmem[i] = $urandom;
            mmem[i] = dmem[i];
        end
        dmem[16'h1fff] = 32'h0;
        mmem[16'h1fff] = 32'h0;
    endtask

    task automatic setData(input int idx, input logic [31:0] val);
        dmem[idx] = val;
        mmem[idx] = val;
    endtask

    // Instruction-at-a-time interpreter; also derives the expected stall/bubble budget.
    task automatic modelRun();
        int p, nextp, steps;
        bit done;
        logic [31:0] w, a, b, simm, addr, val;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, dst;
        bit wr;
        p = 0; steps = 0; done = 0;
        mExec = 0; mStalls = 0; mJumps = 0; mTaken = 0; mHaltData = 32'h0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        while (!done && steps < 5000) begin
            w = imem[p];
            op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
            simm = {{16{w[15]}}, w[15:0]};
            a = mreg[rs]; b = mreg[rt];
            nextp = p + 1; wr = 0; dst = 5'd0; val = 32'h0;
            case (op)
                6'h00: begin
                    dst = rd; wr = 1;
                    case (fn)
                        6'h20: val = a + b;
                        6'h22: val = a - b;
                        6'h24: val = a & b;
                        6'h25: val = a | b;
                        6'h2a: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: wr = 0;
                    endcase
                end
                6'h08: begin dst = rt; wr = 1; val = a + simm; end
                6'h23: begin addr = a + simm; dst = rt; wr = 1; val = mmem[addr[17:2]]; end
                6'h2b: begin
                    addr = a + simm;
                    mmem[addr[17:2]] = b;
                    if (addr == 32'h7fff) begin done = 1; mHaltData = b; end
                end
                6'h04: if (a == b) begin nextp = p + 1 + int'($signed(w[15:0])); mTaken++; end
                6'h05: if (a != b) begin nextp = p + 1 + int'($signed(w[15:0])); mTaken++; end
                6'h02: begin nextp = int'(w[25:0]); mJumps++; end
                default: ;
            endcase
            if (wr && dst != 5'd0) mreg[dst] = val;
            if (!done) begin
                if (op == 6'h23 && rt != 5'd0 && readsReg(imem[p + 1], rt)) mStalls++;
                mExec++;
            end
            p = nextp;
            steps++;
        end
    endtask

    task automatic applyStimulus();
        logic [31:0] rfOr;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rfOr = 32'h0;
        for (int i = 0; i < 32; i++) rfOr = rfOr | dut.rfile_1.rf[i];
        checkOutput("reset.pc", pc, 32'h0);
        checkOutput("reset.aluout", aluout, 32'h0);
        checkOutput("reset.writedata", writedata, 32'h0);
        checkOutput("reset.memwrite", {31'd0, memwrite}, 32'h0);
        checkOutput("reset.stall", {31'd0, dut.stall}, 32'h0);
        checkOutput("reset.rf", rfOr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runProgram(input string name);
        int k;
        bit halted;
        modelRun();
        applyStimulus();
        k = 0; halted = 0; stallCount = 0; haltCycle = -1; haltData = 32'h0;
        pcTrace.delete();
        while (!halted && k < CYCLE_BUDGET) begin
            pcTrace.push_back(pc);
            if (dut.stall === 1'b1) stallCount++;
            if (memwrite === 1'b1) begin
                dmem[aluout[17:2]] = writedata;
                if (aluout === 32'h7fff) begin
                    halted = 1; haltData = writedata; haltCycle = k;
                end
            end
            if (!halted) begin
                @(negedge clk);
                k++;
            end
        end
        checkOutput({name, ".halted"}, {31'd0, halted}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({name, ".haltcycle"}, 32'(haltCycle), 32'(mExec + mStalls + mJumps + 2 * mTaken + 3));
        checkOutput({name, ".stalls"}, 32'(stallCount), 32'(mStalls));
        checkOutput({name, ".haltdata"}, haltData, mHaltData);
        for (int i = 0; i < 32; i++)
            checkOutput($sformatf("%s.r%0d", name, i), dut.rfile_1.rf[i], mreg[i]);
        for (int i = 0; i < 64; i++)
            checkOutput($sformatf("%s.mem%0d", name, i), dmem[i], mmem[i]);
    endtask

    task automatic genRandom(input int len);
        int kind, o;
        logic [4:0] s, t, d;
        logic [15:0] off;
        clearProgram();
        for (int i = 0; i < len; i++) begin
            kind = $urandom_range(0, 11);
            s = 5'($urandom_range(0, 7));
            t = 5'($urandom_range(0, 7));
            d = 5'($urandom_range(0, 7));
            off = 16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            case (kind)
                0, 1, 2: begin
                    case ($urandom_range(0, 4))
                        0: imem[i] = encR(s, t, d, 6'h20);
                        1: imem[i] = encR(s, t, d, 6'h22);
                        2: imem[i] = encR(s, t, d, 6'h24);
                        3: imem[i] = encR(s, t, d, 6'h25);
                        default: imem[i] = encR(s, t, d, 6'h2a);
                    endcase
                end
                3, 4: imem[i] = encI(6'h08, s, d, 16'($urandom));
                5, 6: imem[i] = encI(6'h23, 5'd0, d, off);
                7: imem[i] = encI(6'h2b, 5'd0, t, off);
                8: begin
                    o = $urandom_range(0, (len - 1 - i) < 3 ? (len - 1 - i) : 3);
                    imem[i] = encI(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, s, t, 16'(o));
                end
                9: imem[i] = encJ(26'($urandom_range(i + 1, len)));
                10: imem[i] = encI(6'h3f, 5'd0, t, 16'($urandom));
                default: imem[i] = encR(s, t, d, 6'h27);
            endcase
        end
        imem[len] = encI(6'h2b, 5'd0, 5'($urandom_range(1, 7)), 16'h7fff);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
            mmem[i] = 32'h0;
        end

        clearProgram(); loadData();
        imem[0] = encI(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = encI(6'h08, 5'd0, 5'd2, 16'hfffd);
        imem[2] = encR(5'd1, 5'd2, 5'd3, 6'h20);
        imem[3] = encI(6'h2b, 5'd0, 5'd3, 16'h7fff);
        runProgram("fwd");
        checkOutput("fwd.r1", dut.rfile_1.rf[1], 32'd5);
        checkOutput("fwd.r2", dut.rfile_1.rf[2], 32'hfffffffd);
        checkOutput("fwd.r3", dut.rfile_1.rf[3], 32'd2);
        checkOutput("fwd.nostall", 32'(stallCount), 32'd0);

        clearProgram(); loadData(); setData(0, 32'd7);
        imem[0] = encI(6'h23, 5'd0, 5'd4, 16'd0);
        imem[1] = encR(5'd4, 5'd4, 5'd5, 6'h20);
        imem[2] = encI(6'h2b, 5'd0, 5'd5, 16'h7fff);
        runProgram("loaduse");
        checkOutput("loaduse.stalls", 32'(stallCount), 32'd1);
        checkOutput("loaduse.r5", dut.rfile_1.rf[5], 32'd14);

        clearProgram(); loadData(); setData(0, 32'd7);
        imem[0] = encI(6'h23, 5'd0, 5'd4, 16'd0);
        imem[1] = encI(6'h08, 5'd0, 5'd10, 16'd1);
        imem[2] = encR(5'd4, 5'd4, 5'd5, 6'h20);
        imem[3] = encI(6'h2b, 5'd0, 5'd5, 16'h7fff);
        runProgram("loadgap");
        checkOutput("loadgap.stalls", 32'(stallCount), 32'd0);
        checkOutput("loadgap.r5", dut.rfile_1.rf[5], 32'd14);

        clearProgram(); loadData();
        imem[0] = encI(6'h08, 5'd0, 5'd1, 16'd3);
        imem[1] = encI(6'h08, 5'd1, 5'd1, 16'hffff);
        imem[2] = encI(6'h05, 5'd1, 5'd0, 16'hfffe);
        imem[3] = encI(6'h08, 5'd8, 5'd8, 16'd1);
        imem[4] = encI(6'h08, 5'd9, 5'd9, 16'd1);
        imem[5] = encI(6'h2b, 5'd0, 5'd8, 16'h7fff);
        runProgram("loop");
        checkOutput("loop.r1", dut.rfile_1.rf[1], 32'd0);
        checkOutput("loop.r8", dut.rfile_1.rf[8], 32'd1);
        checkOutput("loop.r9", dut.rfile_1.rf[9], 32'd1);

        clearProgram(); loadData();
        imem[0] = encJ(26'd2);
        imem[1] = encI(6'h08, 5'd0, 5'd6, 16'd1);
        imem[2] = encI(6'h08, 5'd0, 5'd7, 16'd2);
        imem[3] = encI(6'h2b, 5'd0, 5'd7, 16'h7fff);
        runProgram("jump");
        checkOutput("jump.r6", dut.rfile_1.rf[6], 32'd0);
        checkOutput("jump.pc1", pcTrace[1], 32'd4);
        checkOutput("jump.pc2", pcTrace[2], 32'd8);

        clearProgram(); loadData();
        imem[0] = encI(6'h08, 5'd0, 5'd1, 16'h0055);
        imem[1] = encI(6'h2b, 5'd0, 5'd1, 16'h7fff);
        runProgram("halt");
        checkOutput("halt.writedata", haltData, 32'h55);
        checkOutput("halt.cycle", 32'(haltCycle), 32'd4);

        clearProgram(); loadData();
        imem[0] = encI(6'h08, 5'd0, 5'd0, 16'd9);
        imem[1] = encR(5'd0, 5'd0, 5'd7, 6'h22);
        imem[2] = encR(5'd0, 5'd0, 5'd16, 6'h20);
        imem[3] = encI(6'h08, 5'd0, 5'd11, 16'hffff);
        imem[4] = encI(6'h08, 5'd0, 5'd12, 16'd1);
        imem[5] = encR(5'd11, 5'd12, 5'd13, 6'h2a);
        imem[6] = encI(6'h08, 5'd0, 5'd14, 16'd77);
        imem[7] = encI(6'h3f, 5'd0, 5'd14, 16'd5);
        imem[8] = encR(5'd12, 5'd12, 5'd15, 6'h27);
        imem[9] = encI(6'h2b, 5'd0, 5'd13, 16'h7fff);
        runProgram("misc");
        checkOutput("misc.r0", dut.rfile_1.rf[0], 32'd0);
        checkOutput("misc.r16", dut.rfile_1.rf[16], 32'd0);
        checkOutput("misc.slt", dut.rfile_1.rf[13], 32'd1);
        checkOutput("misc.undefop", dut.rfile_1.rf[14], 32'd77);
        checkOutput("misc.undeffn", dut.rfile_1.rf[15], 32'd0);

        for (int n = 0; n < 8; n++) begin
            genRandom(30);
            loadData();
            runProgram($sformatf("rand%0d", n));
        end

        $display("[TB] %0d programs executed", 15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mipse_cpu.md
# mipse_cpu

Five-stage pipelined 32-bit MIPS-subset processor core (IF, ID, EX, MEM, WB) with full forwarding and a one-cycle load-use stall. It drives a word-addressed asynchronous-read instruction memory and a data memory with asynchronous read and synchronous write. It is the top compute block of the test SoC. A store to address 0x7fff is the program-termination convention.

## Interface

- No parameters. Data width 32 (`DATA_W`).
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high; one clock and no other clock domains.
- instr  in  32  instruction word at `pc`, combinational from imem.
- readdata  in  32  data word at `aluout`, combinational from dmem.
- pc  out  32  fetch address; imem indexed by pc[17:2].
- aluout  out  32  MEM-stage ALU result; dmem indexed by aluout[17:2].
- writedata  out  32  MEM-stage store data (forwarded rt value).
- memwrite  out  1  MEM-stage store enable; dmem writes on the rising edge.
- Internal hierarchy names required by benches:
  - load-use stall signal `stall`.
  - register file instance `rfile_1` with array `rf[0:31]`.

## Operation

- ISA:
  - R-type funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2a (signed).
  - I-type opcodes: ADDI 0x08 (sign-extended imm), LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05.
  - J-type: J 0x02.
  - Any other opcode or funct executes as a NOP, with no register or memory write.
- Arithmetic: 32-bit wrap-around, no overflow traps, no delay slots.
- Register file:
  - 32x32, rf[0] reads 0 and writes to it are ignored.
  - Write on the clock edge in WB.
  - Same-cycle read of the register being written returns the new value (write-through bypass).
- Forwarding into EX operands, priority EX/MEM over MEM/WB; never from r0.
- SW store data is taken after forwarding.
- Load-use hazard:
  - Condition: ID instruction reads rs or rt (rt only for R-type, BEQ, BNE, SW) equal to a non-zero rt of an LW in EX.
  - Response: `stall`=1 for one cycle; PC and IF/ID hold; a bubble enters ID/EX.
- J: target {pc+4[31:28], imm26, 2'b00}, resolved in ID; the IF/ID instruction is flushed (1 bubble).
- BEQ/BNE:
  - Target pc+4+(sext(imm16)<<2), resolved in EX.
  - If taken, IF/ID and ID/EX are flushed (2 bubbles).
  - A taken branch in EX has priority over J in ID and over stall.
- Memory ops: byte address = aluout. Only word accesses; bits [1:0] are ignored.

## Timing

- During rst:
  - pc=0.
  - All pipeline registers cleared to NOP, so memwrite=0, aluout=0, writedata=0, stall=0.
  - Register file cleared to 0.
- First fetch of address 0 happens on the cycle after rst deasserts. Reset asserted mid-program gives the same state on the next edge.
- Without hazards, each instruction writes back 4 cycles after fetch; CPI 1.
- LW result is usable by the next-but-one instruction with no stall. The immediately following dependent instruction incurs exactly 1 stall cycle.
- Store: memwrite, aluout and writedata are valid during the MEM cycle; the memory updates at the end of that cycle.
- Taken branch costs 2 cycles; J costs 1 cycle.

## Test plan

- Reset then run: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 (back-to-back, forwarding) -> rf[1]=5, rf[2]=0xfffffffd, rf[3]=2, zero stalls.
- lw r4,0(r0) then add r5,r4,r4 with mem[0]=7 -> exactly 1 cycle with stall=1, rf[5]=14. With one independent instruction between them -> 0 stalls.
- Loop: addi r1,r0,3; loop body addi r1,r1,-1; bne r1,r0,loop -> rf[1]=0. The two instructions after each taken bne never write registers.
- j over addi r6,r0,1 -> rf[6] stays 0, pc sequence skips the target gap, one bubble.
- sw r1,0x7fff(r0) after addi r1,r0,0x55 -> memwrite=1 with aluout=0x7fff and writedata=0x55 in the same cycle.
- addi r0,r0,9; sub r7,r0,r0; slt with negative operand -> rf[0] remains 0, SLT gives 1 for -1<1. An undefined opcode writes nothing.
